// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
//   Shared definitions for the multi-cycle ARM-subset control unit:
//   FSM state encodings, ALUControl codes, instruction op/cmd/cond codes,
//   and the condition-code evaluation helper used by cond_unit.
// ----------------------------------------------------------------------------
package ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXECR  = 4'd6,
      ST_EXECI  = 4'd7,
      ST_ALUWB  = 4'd8,
      ST_BRANCH = 4'd9
   } state_e;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // Evaluate an ARM condition field against stored {N,Z,C,V}; NV never holds.
   function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, r;
      {n, z, c, v} = nzcv;
      case (cond)
         COND_EQ: r = z;
         COND_NE: r = ~z;
         COND_CS: r = c;
         COND_CC: r = ~c;
         COND_MI: r = n;
         COND_PL: r = ~n;
         COND_VS: r = v;
         COND_VC: r = ~v;
         COND_HI: r = c & ~z;
         COND_LS: r = ~c | z;
         COND_GE: r = (n == v);
         COND_LT: r = (n != v);
         COND_GT: r = ~z & (n == v);
         COND_LE: r = z | (n != v);
         COND_AL: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cond_unit.sv
// ----------------------------------------------------------------------------
// cond_unit
//   Holds the NZCV flags register and the registered condition result
//   (condq). condq is captured at the end of DECODE from the stored flags;
//   flags are reloaded from the ALU only when requested and condq is set.
// Ports:
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   cond           : instruction condition field
//   alu_flags      : {N,Z,C,V} from the datapath ALU
//   cond_eval_en   : high in DECODE, captures the condition result
//   flag_wr_req    : high in EXECR/EXECI when the instruction sets flags
//   condq          : registered condition result
// ----------------------------------------------------------------------------
module cond_unit
   import ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic       cond_eval_en,
   input  logic       flag_wr_req,
   output logic       condq
);

   logic [3:0] flags_q, flags_d;
   logic       condq_q, condq_d;

   // Next-value logic for the condition result and the flag register.
   always_comb begin
      condq_d = condq_q;
      flags_d = flags_q;
      if (cond_eval_en) begin
         condq_d = cond_holds(cond, flags_q);
      end else begin
         condq_d = condq_q;
      end
      // A condition-failed flag-setting instruction must leave NZCV intact.
      if (flag_wr_req && condq_q) begin
         flags_d = alu_flags;
      end else begin
         flags_d = flags_q;
      end
   end

   // Flag and condition registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q <= 4'b0000;
         condq_q <= 1'b0;
      end else begin
         flags_q <= flags_d;
         condq_q <= condq_d;
      end
   end

   assign condq = condq_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//   Control unit for the multi-cycle ARM-subset datapath: Moore main FSM,
//   instruction decode and condition/flag handling (in cond_unit).
//   Optional feature macro: MULTICYCLE_CTRL_CMP_EN -- when defined, cmd 1010
//   decodes as CMP (SUB, flags always written subject to condq, no register
//   write); when undefined, cmd 1010 is unsupported.
// Ports:
//   clk, reset                 : rising-edge clock, synchronous active-high reset
//   Instr[19:0]                : IR bits [31:12] (cond, op, funct, Rd)
//   ALUFlags                   : {N,Z,C,V} from the ALU
//   PCWrite/MemWrite/RegWrite/IRWrite : write enables (forced 0 in reset)
//   AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl : selects
//   State                      : current FSM state
// ----------------------------------------------------------------------------
module multicycle_ctrl
   import ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        IRWrite,
   output logic        AdrSrc,
   output logic [1:0]  RegSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [2:0]  ALUControl,
   output logic [3:0]  State
);

   logic [3:0] cond_s;
   logic [1:0] op_s;
   logic       i_bit_s;
   logic [3:0] cmd_s;
   logic       s_bit_s;      // S for data-processing, L for memory
   logic [3:0] rd_s;
   logic       unused_rn_s;

   state_e     state_q, state_d, dec_state_s;
   logic       cmd_ok_s, is_cmp_s;
   logic [2:0] alu_cmd_s;
   logic       condq_s;
   logic       flag_wr_req_s, cond_eval_en_s;
   logic       pc_write_s, mem_write_s, reg_write_s, ir_write_s;

   assign cond_s      = Instr[19:16];
   assign op_s        = Instr[15:14];
   assign i_bit_s     = Instr[13];
   assign cmd_s       = Instr[12:9];
   assign s_bit_s     = Instr[8];
   assign rd_s        = Instr[3:0];
   assign unused_rn_s = ^Instr[7:4];

   // Data-processing cmd decode: ALU operation, support and CMP detection.
   always_comb begin
      cmd_ok_s  = 1'b1;
      is_cmp_s  = 1'b0;
      alu_cmd_s = ALU_ADD;
      case (cmd_s)
         CMD_ADD: alu_cmd_s = ALU_ADD;
         CMD_SUB: alu_cmd_s = ALU_SUB;
         CMD_AND: alu_cmd_s = ALU_AND;
         CMD_ORR: alu_cmd_s = ALU_ORR;
`ifdef MULTICYCLE_CTRL_CMP_EN
         CMD_CMP: begin
            alu_cmd_s = ALU_SUB;
            is_cmp_s  = 1'b1;
         end
`endif
         default: cmd_ok_s = 1'b0;
      endcase
   end

   // Next-state logic of the main FSM.
   always_comb begin
      state_d = ST_FETCH;
      case (state_q)
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            case (op_s)
               OP_MEM: state_d = ST_MEMADR;
               OP_BR:  state_d = ST_BRANCH;
               OP_DP: begin
                  if (!cmd_ok_s) begin
                     state_d = ST_FETCH;
                  end else if (i_bit_s) begin
                     state_d = ST_EXECI;
                  end else begin
                     state_d = ST_EXECR;
                  end
               end
               default: state_d = ST_FETCH;
            endcase
         end
         ST_MEMADR: begin
            if (s_bit_s) begin
               state_d = ST_MEMRD;
            end else begin
               state_d = ST_MEMWR;
            end
         end
         ST_MEMRD:  state_d = ST_MEMWB;
         ST_EXECR, ST_EXECI: begin
            // CMP writes no register, so it skips ALUWB.
            if (is_cmp_s) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_ALUWB;
            end
         end
         default:   state_d = ST_FETCH;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // While reset is high the selects show the FETCH decode even if the
   // register still holds an aborted instruction's state.
   assign dec_state_s = reset ? ST_FETCH : state_q;

   // Moore output decode per state; unlisted selects stay 0.
   always_comb begin
      pc_write_s  = 1'b0;
      mem_write_s = 1'b0;
      reg_write_s = 1'b0;
      ir_write_s  = 1'b0;
      AdrSrc      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'd0;
      ResultSrc   = 2'd0;
      ALUControl  = ALU_ADD;
      case (dec_state_s)
         ST_FETCH: begin
            ir_write_s = 1'b1;
            pc_write_s = 1'b1;
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'd2;
            ResultSrc  = 2'd2;
         end
         ST_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'd2;
            ResultSrc = 2'd2;
         end
         ST_MEMADR: ALUSrcB = 2'd1;
         ST_MEMRD:  AdrSrc  = 1'b1;
         ST_MEMWB: begin
            ResultSrc   = 2'd1;
            reg_write_s = condq_s;
         end
         ST_MEMWR: begin
            AdrSrc      = 1'b1;
            mem_write_s = condq_s;
         end
         ST_EXECR:  ALUControl = alu_cmd_s;
         ST_EXECI: begin
            ALUSrcB    = 2'd1;
            ALUControl = alu_cmd_s;
         end
         ST_ALUWB: begin
            reg_write_s = condq_s;
            pc_write_s  = condq_s & (rd_s == 4'd15);
         end
         ST_BRANCH: begin
            ALUSrcB    = 2'd1;
            ResultSrc  = 2'd2;
            pc_write_s = condq_s;
         end
         default: begin
            ALUControl = ALU_ADD;
         end
      endcase
   end

   assign PCWrite  = pc_write_s  & ~reset;
   assign MemWrite = mem_write_s & ~reset;
   assign RegWrite = reg_write_s & ~reset;
   assign IRWrite  = ir_write_s  & ~reset;

   assign RegSrc = {(op_s == OP_MEM) & ~s_bit_s, (op_s == OP_BR)};
   assign ImmSrc = op_s;
   assign State  = state_q;

   assign cond_eval_en_s = (state_q == ST_DECODE);
   assign flag_wr_req_s  = ((state_q == ST_EXECR) || (state_q == ST_EXECI)) &&
                           (s_bit_s || is_cmp_s);

   cond_unit u_cond_unit (
      .clk          (clk),
      .reset        (reset),
      .cond         (cond_s),
      .alu_flags    (ALUFlags),
      .cond_eval_en (cond_eval_en_s),
      .flag_wr_req  (flag_wr_req_s),
      .condq        (condq_s)
   );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Self-checking bench for multicycle_ctrl. Each test pushes the expected
//   per-cycle output vector of every instruction into a scoreboard queue and
//   then steps the DUT, comparing one popped entry per cycle.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
   logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc;
   logic [2:0]  ALUControl;
   logic [3:0]  State;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
      .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .State(State)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, memw, regw, irw, adr, srca;
      logic [1:0] srcb, res;
      logic [2:0] aluc;
      logic [1:0] regsrc, imm;
   } obs_t;

   typedef struct packed {
      logic [19:0] ins;
      logic [3:0]  fl;
      obs_t        exp;
   } sb_t;

   sb_t  sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   obs_t obs;

   assign obs = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                 ALUSrcB, ResultSrc, ALUControl, RegSrc, ImmSrc};

   // Expected outputs for one state of one instruction, from the state table.
   function automatic obs_t model(input logic [3:0] st, input logic [19:0] ins, input logic cq);
      obs_t m;
      logic [1:0] op;
      logic [3:0] cmd;
      op  = ins[15:14];
      cmd = ins[12:9];
      m = '0;
      m.st = st;
      m.imm = op;
      m.regsrc = {(op == 2'b01) && !ins[8], op == 2'b10};
      case (st)
         4'd0: begin m.irw = 1'b1; m.pcw = 1'b1; m.srca = 1'b1; m.srcb = 2'd2; m.res = 2'd2; end
         4'd1: begin m.srca = 1'b1; m.srcb = 2'd2; m.res = 2'd2; end
         4'd2: m.srcb = 2'd1;
         4'd3: m.adr = 1'b1;
         4'd4: begin m.res = 2'd1; m.regw = cq; end
         4'd5: begin m.adr = 1'b1; m.memw = cq; end
         4'd6, 4'd7: begin
            m.srcb = (st == 4'd7) ? 2'd1 : 2'd0;
            case (cmd)
               4'b0010, 4'b1010: m.aluc = 3'b001;
               4'b0000:          m.aluc = 3'b010;
               4'b1100:          m.aluc = 3'b011;
               default:          m.aluc = 3'b000;
            endcase
         end
         4'd8: begin m.regw = cq; m.pcw = cq && (ins[3:0] == 4'd15); end
         4'd9: begin m.srcb = 2'd1; m.res = 2'd2; m.pcw = cq; end
         default: m = '0;
      endcase
      return m;
   endfunction

   // Queue one instruction: seq lists its n states, first state in the top nibble.
   task automatic push_instr(input logic [19:0] ins, input logic [3:0] fl, input logic cq,
                             input int n, input logic [23:0] seq);
      sb_t e;
      for (int i = 0; i < n; i++) begin
         e.ins = ins;
         e.fl  = fl;
         e.exp = model(seq[4*(n-1-i) +: 4], ins, cq);
         sb_q.push_back(e);
      end
   endtask

   task automatic test_reset();
      obs_t x;
      reset = 1'b1; Instr = 20'h00000; ALUFlags = 4'b0000;
      repeat (3) begin
         @(posedge clk); #1;
         x = model(4'd0, Instr, 1'b0);
         x.pcw = 1'b0; x.irw = 1'b0;
         n_checks++;
         if (obs !== x) begin
            n_errors++;
            $display("FAIL reset: got %h expected %h", obs, x);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_data_processing();
      sb_t e;
      push_instr(20'hE0821, 4'b0000, 1'b1, 4, 24'h0168); // ADD R1,R2,R3
      push_instr(20'hE0021, 4'b0000, 1'b1, 4, 24'h0168); // AND
      push_instr(20'hE3821, 4'b0000, 1'b1, 4, 24'h0178); // ORR immediate
      push_instr(20'hE082F, 4'b0000, 1'b1, 4, 24'h0168); // ADD PC,... writes PC
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         Instr = e.ins; ALUFlags = e.fl;
         #1;
         n_checks++;
         if (obs !== e.exp) begin
            n_errors++;
            $display("FAIL data_processing: state %0d got %h expected %h", e.exp.st, obs, e.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_memory();
      sb_t e;
      push_instr(20'hE5912, 4'b0000, 1'b1, 5, 24'h01234); // LDR
      push_instr(20'hE5812, 4'b0000, 1'b1, 4, 24'h0125);  // STR
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         Instr = e.ins; ALUFlags = e.fl;
         #1;
         n_checks++;
         if (obs !== e.exp) begin
            n_errors++;
            $display("FAIL memory: state %0d got %h expected %h", e.exp.st, obs, e.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch_cond();
      sb_t e;
      push_instr(20'hE0521, 4'b0100, 1'b1, 4, 24'h0168); // SUBS -> Z
      push_instr(20'h0A000, 4'b0000, 1'b1, 3, 24'h019);  // BEQ taken
      push_instr(20'hE0521, 4'b0000, 1'b1, 4, 24'h0168); // SUBS -> 0000
      push_instr(20'h0A000, 4'b0100, 1'b0, 3, 24'h019);  // BEQ not taken
      push_instr(20'hE0521, 4'b1000, 1'b1, 4, 24'h0168); // SUBS -> N
      push_instr(20'hBA000, 4'b0000, 1'b1, 3, 24'h019);  // BLT
      push_instr(20'hAA000, 4'b0000, 1'b0, 3, 24'h019);  // BGE
      push_instr(20'h4A000, 4'b0000, 1'b1, 3, 24'h019);  // BMI
      push_instr(20'h8A000, 4'b0000, 1'b0, 3, 24'h019);  // BHI
      push_instr(20'hFA000, 4'b0000, 1'b0, 3, 24'h019);  // never
      push_instr(20'hEA000, 4'b0000, 1'b1, 3, 24'h019);  // always
      push_instr(20'hE0521, 4'b0010, 1'b1, 4, 24'h0168); // SUBS -> C
      push_instr(20'h8A000, 4'b0000, 1'b1, 3, 24'h019);  // BHI
      push_instr(20'h3A000, 4'b0000, 1'b0, 3, 24'h019);  // BCC
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         Instr = e.ins; ALUFlags = e.fl;
         #1;
         n_checks++;
         if (obs !== e.exp) begin
            n_errors++;
            $display("FAIL branch_cond: instr %h state %0d got %h expected %h", e.ins, e.exp.st, obs, e.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_cond_fail();
      sb_t e;
      push_instr(20'hE0521, 4'b0100, 1'b1, 4, 24'h0168); // SUBS -> Z
      push_instr(20'h10821, 4'b0000, 1'b0, 4, 24'h0168); // ADDNE fails
      push_instr(20'h10521, 4'b0000, 1'b0, 4, 24'h0168); // SUBSNE fails, flags kept
      push_instr(20'h0A000, 4'b0000, 1'b1, 3, 24'h019);  // BEQ still taken
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         Instr = e.ins; ALUFlags = e.fl;
         #1;
         n_checks++;
         if (obs !== e.exp) begin
            n_errors++;
            $display("FAIL cond_fail: instr %h state %0d got %h expected %h", e.ins, e.exp.st, obs, e.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_cmp();
      sb_t e;
      push_instr(20'hE0521, 4'b0000, 1'b1, 4, 24'h0168); // SUBS -> 0000
`ifdef MULTICYCLE_CTRL_CMP_EN
      push_instr(20'hE1520, 4'b0100, 1'b1, 3, 24'h016);  // CMP -> Z
      push_instr(20'h0A000, 4'b0000, 1'b1, 3, 24'h019);  // BEQ taken
      push_instr(20'hE1420, 4'b0000, 1'b1, 3, 24'h016);  // CMP with S=0 -> 0000
      push_instr(20'h0A000, 4'b0100, 1'b0, 3, 24'h019);  // BEQ not taken
`else
      push_instr(20'hE1520, 4'b0100, 1'b1, 2, 24'h01);   // unsupported
      push_instr(20'h0A000, 4'b0000, 1'b0, 3, 24'h019);  // flags untouched
      push_instr(20'hE1420, 4'b0100, 1'b1, 2, 24'h01);
      push_instr(20'h0A000, 4'b0100, 1'b0, 3, 24'h019);
`endif
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         Instr = e.ins; ALUFlags = e.fl;
         #1;
         n_checks++;
         if (obs !== e.exp) begin
            n_errors++;
            $display("FAIL cmp: instr %h state %0d got %h expected %h", e.ins, e.exp.st, obs, e.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_unsupported();
      sb_t e;
      push_instr(20'hE0221, 4'b1111, 1'b1, 2, 24'h01);   // EOR unsupported
      push_instr(20'hEC000, 4'b1111, 1'b1, 2, 24'h01);   // op=11
      push_instr(20'hE0821, 4'b0000, 1'b1, 4, 24'h0168); // recovers
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         Instr = e.ins; ALUFlags = e.fl;
         #1;
         n_checks++;
         if (obs !== e.exp) begin
            n_errors++;
            $display("FAIL unsupported: instr %h state %0d got %h expected %h", e.ins, e.exp.st, obs, e.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_abort();
      sb_t  e;
      obs_t x;
      push_instr(20'hE0521, 4'b0100, 1'b1, 4, 24'h0168); // SUBS -> Z
      push_instr(20'hE0821, 4'b0000, 1'b1, 3, 24'h016);  // ADD up to EXECR
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         Instr = e.ins; ALUFlags = e.fl;
         #1;
         n_checks++;
         if (obs !== e.exp) begin
            n_errors++;
            $display("FAIL reset_abort_pre: state %0d got %h expected %h", e.exp.st, obs, e.exp);
         end
         @(posedge clk); #1;
      end
      // Reset lands in the ALUWB cycle: no write may fire.
      reset = 1'b1;
      #1;
      x = model(4'd0, Instr, 1'b0);
      x.st = 4'd8; x.pcw = 1'b0; x.irw = 1'b0;
      n_checks++;
      if (obs !== x) begin
         n_errors++;
         $display("FAIL reset_abort_cycle: got %h expected %h", obs, x);
      end
      @(posedge clk); #1;
      x.st = 4'd0;
      n_checks++;
      if (obs !== x) begin
         n_errors++;
         $display("FAIL reset_abort_held: got %h expected %h", obs, x);
      end
      reset = 1'b0;
      push_instr(20'h0A000, 4'b0000, 1'b0, 3, 24'h019);  // flags cleared by reset
      push_instr(20'hE0821, 4'b0000, 1'b1, 4, 24'h0168);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         Instr = e.ins; ALUFlags = e.fl;
         #1;
         n_checks++;
         if (obs !== e.exp) begin
            n_errors++;
            $display("FAIL reset_abort_post: state %0d got %h expected %h", e.exp.st, obs, e.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      sb_t e;
      push_instr(20'hE0821, 4'b1111, 1'b1, 4, 24'h0168);  // ADD, S=0: flags ignored
      push_instr(20'hE5912, 4'b0100, 1'b1, 5, 24'h01234); // LDR
      push_instr(20'h0A000, 4'b0100, 1'b0, 3, 24'h019);   // BEQ not taken
      push_instr(20'hE5812, 4'b0000, 1'b1, 4, 24'h0125);  // STR
      push_instr(20'hE3821, 4'b0000, 1'b1, 4, 24'h0178);  // ORR immediate
      push_instr(20'h1A000, 4'b0000, 1'b1, 3, 24'h019);   // BNE taken
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         Instr = e.ins; ALUFlags = e.fl;
         #1;
         n_checks++;
         if (obs !== e.exp) begin
            n_errors++;
            $display("FAIL back_to_back: instr %h state %0d got %h expected %h", e.ins, e.exp.st, obs, e.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_data_processing();
      test_memory();
      test_branch_cond();
      test_cond_fail();
      test_cmp();
      test_unsupported();
      test_reset_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
